// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between NUM_PORTS requesters.
// Each client's request pulse is parked in a per-port slot; one transaction is outstanding at a time.
module sdram_arbiter #(
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned ADDR_W    = 22
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          cli_req,
  input  logic [NUM_PORTS-1:0]          cli_we,
  input  logic [2*NUM_PORTS-1:0]        cli_wm,
  input  logic [ADDR_W*NUM_PORTS-1:0]   cli_address,
  input  logic [16*NUM_PORTS-1:0]       cli_data_write,
  output logic [NUM_PORTS-1:0]          cli_ack,
  output logic [15:0]                   cli_data_read,
  output logic [NUM_PORTS-1:0]          cli_overflow,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [1:0]                    mem_wm,
  output logic [ADDR_W-1:0]             mem_address,
  output logic [15:0]                   mem_data_write,
  input  logic [15:0]                   mem_data_read,
  input  logic                          mem_ack,
  output logic                          busy
);

  localparam int unsigned GrantW = $clog2(NUM_PORTS);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e                   state_q, state_d;
  logic [NUM_PORTS-1:0]     pending_q, pending_d;
  logic [NUM_PORTS-1:0]     overflow_q, overflow_d;
  logic [GrantW-1:0]        grant_q, grant_d;
  logic [GrantW-1:0]        last_grant_q, last_grant_d;

  logic                     slot_we_q   [NUM_PORTS];
  logic                     slot_we_d   [NUM_PORTS];
  logic [1:0]               slot_wm_q   [NUM_PORTS];
  logic [1:0]               slot_wm_d   [NUM_PORTS];
  logic [ADDR_W-1:0]        slot_addr_q [NUM_PORTS];
  logic [ADDR_W-1:0]        slot_addr_d [NUM_PORTS];
  logic [15:0]              slot_data_q [NUM_PORTS];
  logic [15:0]              slot_data_d [NUM_PORTS];

  logic                     mem_req_q, mem_req_d;
  logic                     mem_we_q, mem_we_d;
  logic [1:0]               mem_wm_q, mem_wm_d;
  logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
  logic [15:0]              mem_wdata_q, mem_wdata_d;
  logic [NUM_PORTS-1:0]     cli_ack_q, cli_ack_d;
  logic [15:0]              cli_rdata_q, cli_rdata_d;

  logic                     found;
  logic [GrantW-1:0]        sel;
  logic                     ack_done;
  int                       idx;

  // Round-robin scan starting just after the most recently completed port.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 1; k <= int'(NUM_PORTS); k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= int'(NUM_PORTS)) idx = idx - int'(NUM_PORTS);
      if (!found && pending_q[GrantW'(idx)]) begin
        found = 1'b1;
        sel   = GrantW'(idx);
      end
    end
  end

  assign ack_done = (state_q == StWait) && mem_ack;

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    overflow_d   = overflow_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    slot_we_d    = slot_we_q;
    slot_wm_d    = slot_wm_q;
    slot_addr_d  = slot_addr_q;
    slot_data_d  = slot_data_q;
    mem_req_d    = 1'b0;
    mem_we_d     = mem_we_q;
    mem_wm_d     = mem_wm_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cli_ack_d    = '0;
    cli_rdata_d  = cli_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d     = sel;
          mem_req_d   = 1'b1;
          mem_we_d    = slot_we_q[sel];
          mem_wm_d    = slot_wm_q[sel];
          mem_addr_d  = slot_addr_q[sel];
          mem_wdata_d = slot_data_q[sel];
          state_d     = StWait;
        end
      end
      StWait: begin
        if (mem_ack) begin
          cli_rdata_d         = mem_data_read;
          cli_ack_d[grant_q]  = 1'b1;
          pending_d[grant_q]  = 1'b0;
          last_grant_d        = grant_q;
          state_d             = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Capture runs last so a re-request in the completing cycle overrides the clear.
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (cli_req[i]) begin
        if (!pending_q[i] || (ack_done && (grant_q == GrantW'(i)))) begin
          pending_d[i]   = 1'b1;
          slot_we_d[i]   = cli_we[i];
          slot_wm_d[i]   = cli_wm[2*i +: 2];
          slot_addr_d[i] = cli_address[ADDR_W*i +: ADDR_W];
          slot_data_d[i] = cli_data_write[16*i +: 16];
        end else begin
          overflow_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      pending_q    <= '0;
      overflow_q   <= '0;
      grant_q      <= '0;
      last_grant_q <= GrantW'(NUM_PORTS - 1);
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
        slot_we_q[i]   <= 1'b0;
        slot_wm_q[i]   <= '0;
        slot_addr_q[i] <= '0;
        slot_data_q[i] <= '0;
      end
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wm_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cli_ack_q    <= '0;
      cli_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      slot_we_q    <= slot_we_d;
      slot_wm_q    <= slot_wm_d;
      slot_addr_q  <= slot_addr_d;
      slot_data_q  <= slot_data_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_wm_q     <= mem_wm_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cli_ack_q    <= cli_ack_d;
      cli_rdata_q  <= cli_rdata_d;
    end
  end

  assign cli_ack        = cli_ack_q;
  assign cli_data_read  = cli_rdata_q;
  assign cli_overflow   = overflow_q;
  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_wm         = mem_wm_q;
  assign mem_address    = mem_addr_q;
  assign mem_data_write = mem_wdata_q;
  assign busy           = (state_q == StWait);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: latency, round-robin order, overflow, reset and stray acks.
module tb_sdram_arbiter;

  localparam int NP = 3;
  localparam int AW = 22;

  logic             clk = 1'b0;
  logic             reset;
  logic [NP-1:0]    cli_req;
  logic [NP-1:0]    cli_we;
  logic [2*NP-1:0]  cli_wm;
  logic [AW*NP-1:0] cli_address;
  logic [16*NP-1:0] cli_data_write;
  logic [NP-1:0]    cli_ack;
  logic [15:0]      cli_data_read;
  logic [NP-1:0]    cli_overflow;
  logic             mem_req;
  logic             mem_we;
  logic [1:0]       mem_wm;
  logic [AW-1:0]    mem_address;
  logic [15:0]      mem_data_write;
  logic [15:0]      mem_data_read;
  logic             mem_ack;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  sdram_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .cli_req        (cli_req),
    .cli_we         (cli_we),
    .cli_wm         (cli_wm),
    .cli_address    (cli_address),
    .cli_data_write (cli_data_write),
    .cli_ack        (cli_ack),
    .cli_data_read  (cli_data_read),
    .cli_overflow   (cli_overflow),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_wm         (mem_wm),
    .mem_address    (mem_address),
    .mem_data_write (mem_data_write),
    .mem_data_read  (mem_data_read),
    .mem_ack        (mem_ack),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic we, input logic [1:0] wm,
                          input logic [AW-1:0] a, input logic [15:0] d);
    cli_we[p]              = we;
    cli_wm[2*p +: 2]       = wm;
    cli_address[AW*p +: AW] = a;
    cli_data_write[16*p +: 16] = d;
  endtask

  task automatic wait_mem_req(input string tag);
    for (int k = 0; k < 20; k++) begin
      if (mem_req) break;
      tick();
    end
    chk(tag, mem_req, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " cli_ack"}, cli_ack, 0);
    chk({tag, " overflow"}, cli_overflow, 0);
    chk({tag, " mem_req"}, mem_req, 0);
    chk({tag, " mem_we"}, mem_we, 0);
    chk({tag, " mem_wm"}, mem_wm, 0);
    chk({tag, " mem_addr"}, mem_address, 0);
    chk({tag, " mem_wdata"}, mem_data_write, 0);
    chk({tag, " rdata"}, cli_data_read, 0);
    chk({tag, " busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cli_req = '0; cli_we = '0; cli_wm = '0; cli_address = '0; cli_data_write = '0;
    mem_data_read = '0; mem_ack = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Contention: grants must rotate 0,1,2,0,1,2 with one mem_req per ack.
    for (int p = 0; p < NP; p++) set_port(p, 1'b0, 2'b00, AW'(32'h100 + p), 16'h0);
    cli_req = 3'b111;
    tick();
    cli_req = '0;
    for (int n = 0; n < 6; n++) begin
      wait_mem_req("cont mem_req");
      chk("cont grant addr", mem_address, 64'h100 + n % 3);
      tick();
      chk("cont single req", mem_req, 0);
      tick();
      mem_ack = 1'b1;
      mem_data_read = 16'(16'h5000 + n);
      if (n < 3) cli_req = 3'(3'b001 << (n % 3));
      tick();
      mem_ack = 1'b0;
      cli_req = '0;
      chk("cont ack", cli_ack, 64'(3'b001 << (n % 3)));
      chk("cont rdata", cli_data_read, 64'h5000 + n);
      chk("cont no req at a+1", mem_req, 0);
    end
    tick(); tick();
    chk("cont drained busy", busy, 0);
    chk("cont drained req", mem_req, 0);
    chk("cont overflow", cli_overflow, 0);

    // Single read on port 1.
    set_port(1, 1'b0, 2'b00, 22'h012345, 16'h0);
    cli_req = 3'b010;
    tick();
    cli_req = '0;
    chk("rd req t+1", mem_req, 0);
    tick();
    chk("rd req t+2", mem_req, 1);
    chk("rd addr", mem_address, 22'h012345);
    chk("rd we", mem_we, 0);
    chk("rd busy", busy, 1);
    tick();
    chk("rd req pulse", mem_req, 0);
    tick(); tick();
    chk("rd busy wait", busy, 1);
    mem_ack = 1'b1;
    mem_data_read = 16'hBEEF;
    tick();
    mem_ack = 1'b0;
    chk("rd ack", cli_ack, 3'b010);
    chk("rd data", cli_data_read, 16'hBEEF);
    chk("rd busy after", busy, 0);
    tick();
    chk("rd ack pulse", cli_ack, 0);

    // Single write on port 0.
    set_port(0, 1'b1, 2'b01, 22'h3FFFFF, 16'hA55A);
    cli_req = 3'b001;
    tick();
    cli_req = '0;
    chk("wr busy pre", busy, 0);
    tick();
    chk("wr req", mem_req, 1);
    chk("wr we", mem_we, 1);
    chk("wr wm", mem_wm, 2'b01);
    chk("wr addr", mem_address, 22'h3FFFFF);
    chk("wr data", mem_data_write, 16'hA55A);
    chk("wr busy", busy, 1);
    tick();
    mem_ack = 1'b1;
    mem_data_read = 16'h1234;
    tick();
    mem_ack = 1'b0;
    chk("wr ack", cli_ack, 3'b001);
    chk("wr busy post", busy, 0);

    // Spurious ack while idle.
    tick();
    mem_ack = 1'b1;
    mem_data_read = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    chk("spur ack", cli_ack, 0);
    chk("spur rdata", cli_data_read, 16'h1234);
    chk("spur busy", busy, 0);
    chk("spur req", mem_req, 0);
    tick();
    chk("spur req later", mem_req, 0);

    // Overflow on port 2, then re-request in the ack cycle.
    set_port(2, 1'b0, 2'b00, 22'h02AAAA, 16'h0);
    cli_req = 3'b100;
    tick();
    set_port(2, 1'b0, 2'b00, 22'h02BBBB, 16'h0);
    tick();
    cli_req = '0;
    chk("ovf flag", cli_overflow, 3'b100);
    chk("ovf req", mem_req, 1);
    chk("ovf first addr", mem_address, 22'h02AAAA);
    tick();
    mem_ack = 1'b1;
    mem_data_read = 16'h7777;
    set_port(2, 1'b0, 2'b00, 22'h03CCCC, 16'h0);
    cli_req = 3'b100;
    tick();
    mem_ack = 1'b0;
    cli_req = '0;
    chk("ovf ack1", cli_ack, 3'b100);
    chk("ovf sticky", cli_overflow, 3'b100);
    tick();
    chk("ovf rereq", mem_req, 1);
    chk("ovf rereq addr", mem_address, 22'h03CCCC);
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("ovf ack2", cli_ack, 3'b100);
    chk("ovf no new", cli_overflow, 3'b100);

    // Asynchronous reset while a write is outstanding.
    set_port(0, 1'b1, 2'b11, 22'h000ABC, 16'hC0DE);
    cli_req = 3'b001;
    tick();
    cli_req = '0;
    tick();
    chk("rstw req", mem_req, 1);
    chk("rstw we", mem_we, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("rstw");
    @(negedge clk);
    reset = 1'b0;
    tick();
    mem_ack = 1'b1;
    mem_data_read = 16'hFACE;
    tick();
    mem_ack = 1'b0;
    chk("rstw stray ack", cli_ack, 0);
    chk("rstw stray data", cli_data_read, 0);
    chk("rstw stray busy", busy, 0);
    set_port(0, 1'b0, 2'b00, 22'h000321, 16'h0);
    cli_req = 3'b001;
    tick();
    cli_req = '0;
    tick();
    chk("rstw new req", mem_req, 1);
    chk("rstw new addr", mem_address, 22'h000321);
    tick();
    mem_ack = 1'b1;
    mem_data_read = 16'h4242;
    tick();
    mem_ack = 1'b0;
    chk("rstw new ack", cli_ack, 3'b001);
    chk("rstw new data", cli_data_read, 16'h4242);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
